pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core.
- Generates the per-stage hold vector and the flush strobes that drive every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb).
- Owns branch/jump redirect sequencing, including redirects that arrive while instruction fetch is mid-transaction.
- Keeps stall and flush performance counters.

Parameters:
- ADDR_W, 32, PC/target width
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- stallreq_if  in  1  fetch not complete this cycle
- stallreq_id  in  1  decode hazard (load-use)
- stallreq_ex  in  1  multi-cycle EX op busy
- stallreq_mem  in  1  data memory access not complete
- ex_br_taken  in  1  EX resolved a taken branch/jump this cycle
- ex_br_target  in  ADDR_W  redirect target
- stall  out  6  hold vector: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
- flush_if_id  out  1  load bubble into if_id
- flush_id_ex  out  1  load bubble into id_ex
- pc_redirect  out  1  PC loads pc_target this cycle
- pc_target  out  ADDR_W  redirect address
- redirect_pend  out  1  state == PEND
- cnt_stall  out  CNT_W  cycles with stall != 0
- cnt_flush  out  CNT_W  redirects issued

Behaviour:
- Reset:
  - Reset is asynchronous and active-high.
  - While rst=1, all outputs are 0, state is RUN, and latched target and counters are 0.
  - Release mid-redirect discards the pending redirect.
- Stall vector is combinational; highest priority wins:
  - stallreq_mem → 6'b011111
  - stallreq_ex → 6'b001111
  - stallreq_id → 6'b000111
  - stallreq_if → 6'b000011
  - otherwise 6'b000000
- Downstream register convention: when stall[k]=1 and stall[k+1]=0, the downstream register loads a bubble. Example: stallreq_mem gives stall[4]=1, stall[5]=0, so mem_wb loads we=0.
- Branch acceptance: br_ok = ex_br_taken & ~stall[3]. A branch held in a stalled EX is not acted on; it is re-presented when EX advances.
- States: RUN and PEND.
- RUN, br_ok=1, stallreq_if=0:
  - pc_redirect=1, pc_target=ex_br_target, flush_if_id=1, flush_id_ex=1, all in the same cycle.
  - cnt_flush increments. Stay in RUN.
- RUN, br_ok=1, stallreq_if=1:
  - flush_id_ex=1, pc_redirect=0.
  - Latch ex_br_target and go to PEND next cycle.
  - cnt_flush does not increment yet.
- PEND, stallreq_if=1:
  - Hold. pc_redirect=0.
  - stall follows the priority table; IF stays frozen.
- PEND, stallreq_if=0:
  - The fetch just completed is wrong-path.
  - pc_redirect=1 with the latched target, flush_if_id=1, flush_id_ex=1.
  - cnt_flush increments. Return to RUN.
  - If stallreq_id, stallreq_ex or stallreq_mem is also high in that cycle: the redirect and flushes are still issued; the flush overrides the hold for if_id and id_ex only.
- PEND, br_ok=1 (defensive; cannot occur with correct flushing):
  - Overwrite the latched target with the new one and stay in PEND.
- Flush overrides stall for the targeted register. pc_redirect overrides stall[0].
- Counters: wrap modulo 2^CNT_W. cnt_stall increments on every cycle with stall != 0, including PEND cycles.
- Outputs pc_redirect, pc_target and the flushes are combinational from state and inputs; there is no extra latency.

Decomposition:
- Shared defines header carries:
  - stall bit indices (STALL_PC..STALL_WB) and the stall vector width
  - state encodings RUN=1'b0, PEND=1'b1
  - the four priority stall constants
- Counters go in one sub-module, perf_cnt: a CNT_W enable-increment counter with async reset, instantiated twice.

Test Plan:
- Reset then stallreq_mem=1 → stall=6'b011111; stallreq_mem=0 with stallreq_ex=1 → 6'b001111; no requests → 0; cnt_stall=2.
- RUN, ex_br_taken=1, target 0x00000100, no stalls → same cycle pc_redirect=1, pc_target=0x100, both flushes=1; cnt_flush=1.
- ex_br_taken=1, target 0x200, with stallreq_if=1 for 3 cycles:
  - cycle 0: flush_id_ex=1, pc_redirect=0
  - cycles 1-2: redirect_pend=1
  - cycle 3 (if drops): pc_redirect=1, target 0x200, flush_if_id=1
  - then RUN
- ex_br_taken=1 with stallreq_mem=1 → no redirect, no flush; mem drops next cycle with taken still high → redirect issued.
- PEND, assert rst asynchronously between clock edges → redirect_pend, counters and outputs 0 immediately; after release, stallreq_if drop gives no redirect.
- PEND exit coinciding with stallreq_ex=1 → pc_redirect=1, flush_if_id=1, flush_id_ex=1, stall=6'b001111.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall bit positions,
// sequencer state encodings and the priority stall patterns.
package pipe_ctrl_pkg;

    localparam int STALL_W   = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Each pattern holds the requesting stage and everything upstream of it
    localparam logic [STALL_W-1:0] STALL_VEC_MEM = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_VEC_EX  = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_VEC_ID  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_VEC_IF  = 6'b000011;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Free-running enable-increment performance counter, wraps modulo 2^CNT_W.
module perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage hold vector, bubble strobes and branch
// redirect sequencing, deferring redirects while fetch is mid-transaction.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               ex_br_taken,
    input  logic [ADDR_W-1:0]  ex_br_target,
    output logic [STALL_W-1:0] stall,
    output logic               flush_if_id,
    output logic               flush_id_ex,
    output logic               pc_redirect,
    output logic [ADDR_W-1:0]  pc_target,
    output logic               redirect_pend,
    output logic [CNT_W-1:0]   cnt_stall,
    output logic [CNT_W-1:0]   cnt_flush
);

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [ADDR_W-1:0]  r_target;
    logic [ADDR_W-1:0]  w_target_next;
    logic [STALL_W-1:0] w_stall;
    logic               w_br_ok;
    logic               w_redirect;
    logic [ADDR_W-1:0]  w_redirect_target;
    logic               w_flush_if_id;
    logic               w_flush_id_ex;

    always_comb begin
        if (stallreq_mem)     w_stall = STALL_VEC_MEM;
        else if (stallreq_ex) w_stall = STALL_VEC_EX;
        else if (stallreq_id) w_stall = STALL_VEC_ID;
        else if (stallreq_if) w_stall = STALL_VEC_IF;
        else                  w_stall = '0;
    end

    // A branch sitting in a held EX stage is re-presented once EX advances
    assign w_br_ok = ex_br_taken & ~w_stall[STALL_EX];

    always_comb begin
        w_state_next      = r_state;
        w_target_next     = r_target;
        w_redirect        = 1'b0;
        w_redirect_target = '0;
        w_flush_if_id     = 1'b0;
        w_flush_id_ex     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_br_ok) begin
                    w_flush_id_ex = 1'b1;
                    if (!stallreq_if) begin
                        w_redirect        = 1'b1;
                        w_redirect_target = ex_br_target;
                        w_flush_if_id     = 1'b1;
                    end else begin
                        w_target_next = ex_br_target;
                        w_state_next  = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (w_br_ok) begin
                    w_flush_id_ex = 1'b1;
                    w_target_next = ex_br_target;
                end else if (!stallreq_if) begin
                    // The fetch completing now is wrong-path: squash it and steer
                    w_redirect        = 1'b1;
                    w_redirect_target = r_target;
                    w_flush_if_id     = 1'b1;
                    w_flush_id_ex     = 1'b1;
                    w_state_next      = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_target <= '0;
        end else begin
            r_state  <= w_state_next;
            r_target <= w_target_next;
        end
    end

    // Combinational outputs are forced quiet for the whole reset window
    assign stall         = rst ? '0 : w_stall;
    assign flush_if_id   = ~rst & w_flush_if_id;
    assign flush_id_ex   = ~rst & w_flush_id_ex;
    assign pc_redirect   = ~rst & w_redirect;
    assign pc_target     = rst ? '0 : w_redirect_target;
    assign redirect_pend = ~rst & (r_state == ST_PEND);

    perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst   (rst),
        .i_en  (|w_stall),
        .o_cnt (cnt_stall)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_redirect),
        .o_cnt (cnt_flush)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected outputs queued per driven cycle,
// popped and compared mid-cycle.
module tb_pipe_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        fif;
        logic        fie;
        logic        red;
        logic [31:0] tgt;
        logic        pend;
        logic [31:0] cs;
        logic [31:0] cf;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic              ex_br_taken;
    logic [ADDR_W-1:0] ex_br_target;
    logic [5:0]        stall;
    logic              flush_if_id, flush_id_ex, pc_redirect, redirect_pend;
    logic [ADDR_W-1:0] pc_target;
    logic [CNT_W-1:0]  cnt_stall, cnt_flush;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_cs = 0;
    logic [31:0] m_cf = 0;

    pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .ex_br_taken   (ex_br_taken),
        .ex_br_target  (ex_br_target),
        .stall         (stall),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .pc_redirect   (pc_redirect),
        .pc_target     (pc_target),
        .redirect_pend (redirect_pend),
        .cnt_stall     (cnt_stall),
        .cnt_flush     (cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic br, input logic [31:0] tgt);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        ex_br_taken  = br;
        ex_br_target = tgt;
    endtask

    task automatic sb_push(input string name, input logic [5:0] st, input logic fif,
                           input logic fie, input logic red, input logic [31:0] tgt,
                           input logic pend);
        exp_t e;
        e.name = name; e.stall = st; e.fif = fif; e.fie = fie; e.red = red;
        e.tgt = tgt; e.pend = pend; e.cs = m_cs; e.cf = m_cf;
        sb_q.push_back(e);
    endtask

    // Pops one expectation, compares every output, then advances the counter model
    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        check({e.name, ".stall"}, 64'(stall), 64'(e.stall));
        check({e.name, ".fif"},   64'(flush_if_id), 64'(e.fif));
        check({e.name, ".fie"},   64'(flush_id_ex), 64'(e.fie));
        check({e.name, ".red"},   64'(pc_redirect), 64'(e.red));
        if (e.red) check({e.name, ".tgt"}, 64'(pc_target), 64'(e.tgt));
        check({e.name, ".pend"},  64'(redirect_pend), 64'(e.pend));
        check({e.name, ".cs"},    64'(cnt_stall), 64'(e.cs));
        check({e.name, ".cf"},    64'(cnt_flush), 64'(e.cf));
        $display("[TB] %s stall=%b fif=%b fie=%b red=%b tgt=0x%0h pend=%b cs=%0d cf=%0d",
                 e.name, stall, flush_if_id, flush_id_ex, pc_redirect, pc_target,
                 redirect_pend, cnt_stall, cnt_flush);
        if (e.stall != 6'd0) m_cs = m_cs + 1;
        if (e.red)           m_cf = m_cf + 1;
    endtask

    // One clock: inputs applied just after the edge, outputs checked mid-cycle
    task automatic step(input string name, input logic [3:0] req, input logic br,
                        input logic [31:0] tgt, input logic [5:0] st, input logic fif,
                        input logic fie, input logic red, input logic [31:0] etgt,
                        input logic pend);
        drive(req, br, tgt);
        sb_push(name, st, fif, fie, red, etgt, pend);
        #4;
        sb_check();
        @(posedge clk);
        #1;
    endtask

    // req = {mem, ex, id, if}
    initial begin
        rst = 1'b1;
        drive(4'b1000, 1'b1, 32'h0000_0100);
        #3;
        sb_push("in_reset", 6'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        sb_check();
        m_cs = 0; m_cf = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("mem_stall", 4'b1000, 0, 32'h0,   6'b011111, 0, 0, 0, 32'h0,   0);
        step("ex_stall",  4'b0100, 0, 32'h0,   6'b001111, 0, 0, 0, 32'h0,   0);
        step("id_stall",  4'b0010, 0, 32'h0,   6'b000111, 0, 0, 0, 32'h0,   0);
        step("idle",      4'b0000, 0, 32'h0,   6'b000000, 0, 0, 0, 32'h0,   0);
        step("br_fast",   4'b0000, 1, 32'h100, 6'b000000, 1, 1, 1, 32'h100, 0);
        step("post_br",   4'b0000, 0, 32'h0,   6'b000000, 0, 0, 0, 32'h0,   0);
        step("br_if_c0",  4'b0001, 1, 32'h200, 6'b000011, 0, 1, 0, 32'h0,   0);
        step("pend_c1",   4'b0001, 0, 32'h0,   6'b000011, 0, 0, 0, 32'h0,   1);
        step("pend_c2",   4'b0001, 0, 32'h0,   6'b000011, 0, 0, 0, 32'h0,   1);
        step("pend_exit", 4'b0000, 0, 32'h0,   6'b000000, 1, 1, 1, 32'h200, 1);
        step("back_run",  4'b0000, 0, 32'h0,   6'b000000, 0, 0, 0, 32'h0,   0);
        step("br_memhld", 4'b1000, 1, 32'h300, 6'b011111, 0, 0, 0, 32'h0,   0);
        step("br_exhld",  4'b0100, 1, 32'h300, 6'b001111, 0, 0, 0, 32'h0,   0);
        step("br_rels",   4'b0000, 1, 32'h300, 6'b000000, 1, 1, 1, 32'h300, 0);
        step("br_if_400", 4'b0001, 1, 32'h400, 6'b000011, 0, 1, 0, 32'h0,   0);

        // Still pending: check normally, then hit reset between edges
        drive(4'b0001, 1'b0, 32'h0);
        sb_push("pend_prerst", 6'b000011, 0, 0, 0, 32'h0, 1);
        #4;
        sb_check();
        #2;
        rst = 1'b1;
        #1;
        m_cs = 0; m_cf = 0;
        sb_push("async_rst", 6'd0, 0, 0, 0, 32'h0, 0);
        sb_check();
        m_cs = 0; m_cf = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("rls_nored", 4'b0000, 0, 32'h0,   6'b000000, 0, 0, 0, 32'h0,   0);
        step("br_if_500", 4'b0001, 1, 32'h500, 6'b000011, 0, 1, 0, 32'h0,   0);
        step("exit_ex",   4'b0100, 0, 32'h0,   6'b001111, 1, 1, 1, 32'h500, 1);
        step("final",     4'b0000, 0, 32'h0,   6'b000000, 0, 0, 0, 32'h0,   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
